// File: rtl/seg7_scan_mux_if.sv
// Operand and display bundle for seg7_scan_mux.
// The master side is the datapath/board; the slave side is the scan driver.
interface seg7_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] a;
    logic [4*NUM_DIGITS-1:0] b;
    logic                    sel;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output a,
        output b,
        output sel,
        input  seg,
        input  an,
        input  frame_tick
    );

    modport slave (
        input  a,
        input  b,
        input  sel,
        output seg,
        output an,
        output frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-frame operand snapshot.
// Define SEG7_SCAN_MUX_LZ_BLANK_EN to blank leading-zero digits.
module seg7_scan_mux #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SHOW_CYCLES = 100000,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input logic            clk,
    input logic            rst_n,
    seg7_scan_mux_if.slave bus
);
    localparam int unsigned MaxLen = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLen) + 1;
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW  = 4 * NUM_DIGITS;

    localparam logic [CntW-1:0] ShowLast = CntW'(SHOW_CYCLES - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        StDead,
        StShow
    } state_e;

    // Phase that opens every frame; SHOW directly when the dead time is zero.
    localparam state_e StFirst = (DEAD_CYCLES > 0) ? StDead : StShow;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DataW-1:0]      snap_q, snap_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  start_q;
    logic                  load;
    logic [3:0]            digit;
    logic                  blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Sequencing: the first clock after reset release opens frame 0 in place.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        if (start_q) begin
            state_d = StFirst;
            idx_d   = '0;
            cnt_d   = '0;
            load    = 1'b1;
        end else begin
            unique case (state_q)
                StDead: begin
                    if (cnt_q == DeadLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        state_d = StFirst;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
                        load    = (idx_q == IdxLast);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            endcase
        end
        snap_d = load ? (bus.sel ? bus.b : bus.a) : snap_q;
    end

    // Decode from next-state values so anode and cathodes always land on the same edge.
    always_comb begin
        digit = snap_d[3:0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (idx_d == IdxW'(i)) begin
                digit = snap_d[4*i +: 4];
            end
        end
`ifdef SEG7_SCAN_MUX_LZ_BLANK_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            blank    = 1'b0;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                zero_run = zero_run && (snap_d[4*i +: 4] == 4'h0);
                if (idx_d == IdxW'(i)) begin
                    blank = zero_run;
                end
            end
        end
`else
        blank = 1'b0;
`endif
        an_d  = '1;
        seg_d = '1;
        if (state_d == StShow) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_d != IdxW'(i));
            end
            seg_d = blank ? 7'h7F : hex_decode(digit);
        end
        tick_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StDead;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            seg_q   <= '1;
            an_q    <= '1;
            tick_q  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            start_q <= 1'b0;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: table of per-frame operands, expected digit patterns queued as
// each operand is driven and popped as digits are strobed; a second instance has no dead time.
module tb_seg7_scan_mux;
    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;
    localparam int unsigned DC = 2;
    localparam int NV = 7;

`ifdef SEG7_SCAN_MUX_LZ_BLANK_EN
    localparam logic [6:0] ZB = 7'b1111111;
`else
    localparam logic [6:0] ZB = 7'b1000000;
`endif

    typedef struct packed {
        logic [15:0]     a;
        logic [15:0]     b;
        logic            sel;
        logic [3:0][6:0] exp_seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();
    seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus0 ();

    seg7_scan_mux #(
        .NUM_DIGITS (ND),
        .SHOW_CYCLES(SC),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    seg7_scan_mux #(
        .NUM_DIGITS (ND),
        .SHOW_CYCLES(SC),
        .DEAD_CYCLES(0)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    int nchecks = 0;
    int nfail = 0;
    vec_t vecs [NV];
    logic [6:0] sb_q [$];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic sel,
                                input logic [6:0] d0, input logic [6:0] d1,
                                input logic [6:0] d2, input logic [6:0] d3);
        vec_t v;
        v.a = a;
        v.b = b;
        v.sel = sel;
        v.exp_seg = {d3, d2, d1, d0};
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        bus.a = v.a;
        bus.b = v.b;
        bus.sel = v.sel;
        for (int i = 0; i < int'(ND); i++) sb_q.push_back(v.exp_seg[i]);
    endtask

    // Entered on the frame_tick sample; leaves on the next frame's frame_tick sample.
    task automatic run_frame(input int k);
        for (int d = 0; d < int'(ND); d++) begin
            int gap;
            int show;
            logic [ND-1:0] ea;
            logic [6:0] es;
            gap = 0;
            show = 0;
            while (bus.an == '1 && gap < 64) begin
                gap++;
                @(negedge clk);
            end
            check("dead_gap", gap, DC);
            ea = ~(ND'(1) << d);
            check("an_digit", bus.an, ea);
            check("sb_nonempty", sb_q.size() != 0, 1);
            es = 7'h7F;
            if (sb_q.size() != 0) es = sb_q.pop_front();
            while (bus.an == ea && show < 64) begin
                check("seg_digit", bus.seg, es);
                show++;
                @(negedge clk);
            end
            check("show_len", show, SC);
            if (d == 0 && k + 1 < NV) drive_vec(vecs[k+1]);
        end
        check("frame_tick", bus.frame_tick, 1);
    endtask

    int unsigned since_tick = 0;
    bit have_tick = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            have_tick = 1'b0;
            since_tick = 0;
        end else if (mon_en) begin
            check("an_onehot", $countones(~bus.an) <= 1, 1);
            if (bus.an == '1) check("dead_seg", bus.seg, 7'h7F);
            since_tick++;
            if (bus.frame_tick) begin
                if (have_tick) check("tick_period", since_tick, ND * (SC + DC));
                have_tick = 1'b1;
                since_tick = 0;
            end
        end
    end

    int unsigned since0 = 0;
    bit have0 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            have0 = 1'b0;
            since0 = 0;
        end else if (mon_en) begin
            if (have0) check("dz_no_gap", bus0.an != '1, 1);
            since0++;
            if (bus0.frame_tick) begin
                if (have0) check("dz_period", since0, ND * SC);
                have0 = 1'b1;
                since0 = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = mk(16'h1234, 16'h0000, 1'b0, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
        vecs[1] = mk(16'h1234, 16'hABCF, 1'b1, 7'b0001110, 7'b1000110, 7'b0000011, 7'b0001000);
        vecs[2] = mk(16'h5678, 16'hABCF, 1'b0, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010);
        vecs[3] = mk(16'h5678, 16'h9DE0, 1'b1, 7'b1000000, 7'b0000110, 7'b0100001, 7'b0010000);
        vecs[4] = mk(16'h0050, 16'h0A00, 1'b0, 7'b1000000, 7'b0010010, ZB, ZB);
        vecs[5] = mk(16'h0050, 16'h0A00, 1'b1, 7'b1000000, 7'b1000000, 7'b0001000, ZB);
        vecs[6] = mk(16'h0000, 16'h0A00, 1'b0, 7'b1000000, ZB, ZB, ZB);

        bus.a = '0;
        bus.b = '0;
        bus.sel = 1'b0;
        bus0.a = 16'h1234;
        bus0.b = 16'h0000;
        bus0.sel = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_an", bus.an, 4'b1111);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_tick", bus.frame_tick, 0);
        check("rst_an_dz", bus0.an, 4'b1111);

        drive_vec(vecs[0]);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("tick_after_release", bus.frame_tick, 1);
        check("dz_show_at_tick", bus0.an, 4'b1110);

        for (int k = 0; k < NV; k++) run_frame(k);

        n = 0;
        while (bus.an != 4'b1011 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("reach_digit2", bus.an, 4'b1011);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", bus.an, 4'b1111);
        check("async_rst_seg", bus.seg, 7'h7F);
        check("async_rst_tick", bus.frame_tick, 0);

        drive_vec(mk(16'hFEDC, 16'h0000, 1'b0, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("tick_after_rerelease", bus.frame_tick, 1);
        run_frame(NV);
        check("sb_drained", sb_q.size(), 0);

        n = 0;
        while (bus0.an != 4'b1110 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("dz_an0", bus0.an, 4'b1110);
        n = 0;
        while (bus0.an == 4'b1110 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("dz_show_len", n, SC);
        check("dz_next_digit", bus0.an, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
